// File: rtl/ibex_pkg.sv
// ibex_pkg: ALU operation types, bitmanip config and multi-cycle sequencing helpers
package ibex_pkg;
    typedef enum logic [5:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SRA, ALU_SRL, ALU_SLL,
        ALU_LT, ALU_LTU, ALU_EQ, ALU_NE, ALU_CLZ, ALU_CTZ, ALU_PCNT,
        ALU_ROR, ALU_ROL, ALU_FSR, ALU_FSL, ALU_CMIX, ALU_CMOV,
        ALU_BEXT, ALU_BDEP,
        ALU_CRC32_B, ALU_CRC32C_B, ALU_CRC32_H, ALU_CRC32C_H, ALU_CRC32_W, ALU_CRC32C_W
    } alu_op_e;
    typedef enum integer {RV32BNone, RV32BBalanced, RV32BOTEarlGrey, RV32BFull} rv32b_e;
    typedef enum logic [2:0] {MC_IDLE = 3'b001, MC_LAST = 3'b010, MC_ITER = 3'b100} alu_mc_state_e;
    typedef enum logic [1:0] {ALU_MC_SINGLE, ALU_MC_TWO, ALU_MC_ITER} alu_mc_class_e;
    localparam int unsigned ALU_MC_ITER_MAX = 32;
    function automatic alu_mc_class_e alu_mc_class(alu_op_e op, rv32b_e cfg);
        alu_mc_class = ALU_MC_SINGLE;
        if (cfg != RV32BNone) begin
            case (op)
                ALU_ROL, ALU_ROR, ALU_FSL, ALU_FSR, ALU_CMIX, ALU_CMOV: alu_mc_class = ALU_MC_TWO;
                ALU_BEXT, ALU_BDEP, ALU_CRC32_B, ALU_CRC32C_B, ALU_CRC32_H, ALU_CRC32C_H,
                ALU_CRC32_W, ALU_CRC32C_W: alu_mc_class = ALU_MC_ITER;
                default: alu_mc_class = ALU_MC_SINGLE;
            endcase
        end
    endfunction
endpackage

// File: rtl/ibex_alu_imd_regs.sv
// ibex_alu_imd_regs: pair of 32-bit intermediate-value registers with per-register write enables
module ibex_alu_imd_regs (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] d_i [2],
    input  logic [1:0]  we_i,
    output logic [31:0] q_o [2]
);
    logic [31:0] r_q [2];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '{default: '0};
        end else begin
            for (int k = 0; k < 2; k++) if (we_i[k]) r_q[k] <= d_i[k];
        end
    end
    assign q_o = r_q;
endmodule

// File: rtl/ibex_alu_mc_ctrl.sv
// ibex_alu_mc_ctrl: multi-cycle ALU sequencer; IBEX_ALU_MC_PERF_EN adds stall counter and op-done pulse
module ibex_alu_mc_ctrl
    import ibex_pkg::*;
#(
    parameter rv32b_e      RV32B       = RV32BNone,
    parameter int unsigned ITER_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  alu_op_e     operator_i,
    input  logic        kill_i,
    input  logic [31:0] imd_val_d_i [2],
    input  logic [1:0]  imd_val_we_i,
    output logic [31:0] imd_val_q_o [2],
    output logic        instr_first_cycle_o,
    output logic        stall_o,
    output logic        done_o,
`ifdef IBEX_ALU_MC_PERF_EN
    output logic [31:0] mc_stall_cnt_o,
    output logic        mc_op_done_o,
`endif
    output logic        busy_o
);
    localparam int unsigned CW = $clog2(ALU_MC_ITER_MAX);
    alu_mc_state_e r_state;
    logic [CW-1:0] r_cnt;
    alu_mc_class_e w_cls;
    logic          w_go;
    logic [1:0]    w_we;
    assign w_cls               = alu_mc_class(operator_i, RV32B);
    assign w_go                = req_i & ~kill_i;
    assign w_we                = imd_val_we_i & {2{w_go}};
    assign busy_o              = r_state != MC_IDLE;
    assign instr_first_cycle_o = ~busy_o;
    assign done_o  = w_go & (r_state == MC_LAST | r_state == MC_IDLE & w_cls == ALU_MC_SINGLE);
    assign stall_o = w_go & (r_state == MC_ITER | r_state == MC_IDLE & w_cls != ALU_MC_SINGLE);
    // The counter loads ITER_CYCLES-2 so that IDLE + ITER cycles + LAST spans exactly ITER_CYCLES.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else if (!w_go || r_state == MC_LAST) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else if (r_state == MC_ITER) begin
            r_state <= (r_cnt == CW'(1)) ? MC_LAST : MC_ITER;
            r_cnt   <= r_cnt - 1'b1;
        end else if (w_cls == ALU_MC_TWO) begin
            r_state <= MC_LAST;
        end else if (w_cls == ALU_MC_ITER) begin
            r_state <= MC_ITER;
            r_cnt   <= CW'(ITER_CYCLES - 2);
        end
    end
    ibex_alu_imd_regs u_imd (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (imd_val_d_i),
        .we_i  (w_we),
        .q_o   (imd_val_q_o)
    );
`ifdef IBEX_ALU_MC_PERF_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_stall_cnt <= '0;
        else if (stall_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
    assign mc_stall_cnt_o = r_stall_cnt;
    assign mc_op_done_o   = done_o & busy_o;
`endif
    a_op_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_o && req_i |-> operator_i == $past(operator_i));
    a_iter_range: assert property (@(posedge clk_i)
        ITER_CYCLES >= 3 && ITER_CYCLES <= ALU_MC_ITER_MAX);
    a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot(r_state));
    a_done_req: assert property (@(posedge clk_i) disable iff (!rst_ni) done_o |-> req_i);
    a_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(done_o && stall_o));
endmodule

// File: tb/tb_ibex_alu_mc_ctrl.sv
// tb_ibex_alu_mc_ctrl: randomized self-checking bench against an op-latency and imd-register model
module tb_ibex_alu_mc_ctrl;
    import ibex_pkg::*;
    localparam int N = 4;
    logic        clk = 0, rst_ni = 0, req = 0, kill = 0;
    alu_op_e     op = ALU_ADD;
    logic [31:0] d [2];
    logic [1:0]  we = 0;
    logic [31:0] q [2], qn [2];
    logic        first, stall, done, busy, first_n, stall_n, done_n, busy_n;
`ifdef IBEX_ALU_MC_PERF_EN
    logic [31:0] scnt, scnt_n;
    logic        opd, opd_n;
`endif
    logic [31:0] m_q [2];
    int          exp_scnt = 0;
    int          n_vec = 0, n_err = 0;
    alu_op_e two_ops [6] = '{ALU_ROL, ALU_ROR, ALU_FSL, ALU_FSR, ALU_CMIX, ALU_CMOV};
    alu_op_e iter_ops [8] = '{ALU_BEXT, ALU_BDEP, ALU_CRC32_B, ALU_CRC32_H, ALU_CRC32_W,
                              ALU_CRC32C_B, ALU_CRC32C_H, ALU_CRC32C_W};
    alu_op_e single_ops [10] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL,
                                 ALU_SRL, ALU_SRA, ALU_LT, ALU_CLZ};

    always #5 clk = ~clk;

    ibex_alu_mc_ctrl #(.RV32B(RV32BFull), .ITER_CYCLES(N)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .operator_i(op), .kill_i(kill),
        .imd_val_d_i(d), .imd_val_we_i(we), .imd_val_q_o(q),
        .instr_first_cycle_o(first), .stall_o(stall), .done_o(done),
`ifdef IBEX_ALU_MC_PERF_EN
        .mc_stall_cnt_o(scnt), .mc_op_done_o(opd),
`endif
        .busy_o(busy));

    ibex_alu_mc_ctrl #(.RV32B(RV32BNone), .ITER_CYCLES(N)) dut_n (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .operator_i(op), .kill_i(kill),
        .imd_val_d_i(d), .imd_val_we_i(we), .imd_val_q_o(qn),
        .instr_first_cycle_o(first_n), .stall_o(stall_n), .done_o(done_n),
`ifdef IBEX_ALU_MC_PERF_EN
        .mc_stall_cnt_o(scnt_n), .mc_op_done_o(opd_n),
`endif
        .busy_o(busy_n));

    function automatic int lat_of(alu_op_e o);
        foreach (two_ops[i]) if (two_ops[i] == o) return 2;
        foreach (iter_ops[i]) if (iter_ops[i] == o) return N;
        return 1;
    endfunction

    // One instruction from its req cycle to done (or abort); ab_kill selects kill vs dropping req.
    task automatic run_op(input alu_op_e o, input int ab_at, input bit ab_kill,
                          input int wk, input logic [1:0] wwe, input logic [31:0] wd0, input logic [31:0] wd1);
        int L = lat_of(o);
        int last = (ab_at >= 0 && ab_at < L) ? ab_at : L - 1;
        for (int k = 0; k <= last; k++) begin
            bit   ab = (k == ab_at);
            logic e_done, e_stall;
            @(negedge clk);
            op   = o;
            req  = !(ab && !ab_kill);
            kill = ab && ab_kill;
            if (k == wk) begin
                we = wwe; d[0] = wd0; d[1] = wd1;
            end else begin
                we = 2'($urandom_range(3)); d[0] = $urandom; d[1] = $urandom;
            end
            e_done  = !ab && k == L - 1;
            e_stall = !ab && k < L - 1;
            #1;
            n_vec++; if (first !== (k == 0)) begin n_err++; $display("FAIL first %s k=%0d got=%b exp=%b", o.name(), k, first, k == 0); end
            n_vec++; if (busy !== (k > 0)) begin n_err++; $display("FAIL busy %s k=%0d got=%b exp=%b", o.name(), k, busy, k > 0); end
            n_vec++; if (done !== e_done) begin n_err++; $display("FAIL done %s k=%0d got=%b exp=%b", o.name(), k, done, e_done); end
            n_vec++; if (stall !== e_stall) begin n_err++; $display("FAIL stall %s k=%0d got=%b exp=%b", o.name(), k, stall, e_stall); end
            for (int i = 0; i < 2; i++) begin
                n_vec++; if (q[i] !== m_q[i]) begin n_err++; $display("FAIL imd%0d %s k=%0d got=%h exp=%h", i, o.name(), k, q[i], m_q[i]); end
                n_vec++; if (qn[i] !== m_q[i]) begin n_err++; $display("FAIL imd%0d_none %s k=%0d got=%h exp=%h", i, o.name(), k, qn[i], m_q[i]); end
            end
            if (k == 0 && !ab) begin
                n_vec++; if (done_n !== 1'b1 || stall_n !== 1'b0 || busy_n !== 1'b0) begin
                    n_err++; $display("FAIL none_single %s got done=%b stall=%b busy=%b exp done=1 stall=0 busy=0", o.name(), done_n, stall_n, busy_n);
                end
            end
`ifdef IBEX_ALU_MC_PERF_EN
            n_vec++; if (opd !== (e_done && L > 1)) begin n_err++; $display("FAIL op_done %s k=%0d got=%b exp=%b", o.name(), k, opd, e_done && L > 1); end
`endif
            if (req && !kill) for (int i = 0; i < 2; i++) if (we[i]) m_q[i] = d[i];
            if (e_stall) exp_scnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req = 0; kill = 0; we = 2'($urandom_range(3)); d[0] = $urandom; d[1] = $urandom;
            #1;
            n_vec++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || first !== 1'b1) begin
                n_err++; $display("FAIL idle got busy=%b done=%b stall=%b first=%b exp 0 0 0 1", busy, done, stall, first);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++; if (first !== 1'b1 || stall !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s got first=%b stall=%b done=%b busy=%b exp 1 0 0 0", tag, first, stall, done, busy);
        end
        n_vec++; if (q[0] !== 32'h0 || q[1] !== 32'h0 || qn[0] !== 32'h0 || qn[1] !== 32'h0) begin
            n_err++; $display("FAIL %s_imd got %h %h %h %h exp 0", tag, q[0], q[1], qn[0], qn[1]);
        end
`ifdef IBEX_ALU_MC_PERF_EN
        n_vec++; if (scnt !== 32'h0) begin n_err++; $display("FAIL %s_cnt got=%0d exp=0", tag, scnt); end
`endif
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_ni = 1;
        m_q[0] = 0; m_q[1] = 0; exp_scnt = 0;
    endtask

    task automatic test_single;
        run_op(ALU_ADD, -1, 0, -1, 0, 0, 0);
        run_op(ALU_XOR, -1, 0, 0, 2'b11, 32'hA5A5_0001, 32'h5A5A_0002);
        run_op(ALU_SRA, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_two;
        run_op(ALU_ROL, -1, 0, -1, 0, 0, 0);
        run_op(ALU_CMOV, -1, 0, 1, 2'b10, 0, 32'hCAFE_F00D);
    endtask

    task automatic test_iter;
        run_op(ALU_BDEP, -1, 0, 1, 2'b01, 32'hDEAD_BEEF, 32'h0);
        run_op(ALU_CRC32C_H, -1, 0, -1, 0, 0, 0);
    endtask

    task automatic test_kill;
        run_op(ALU_CRC32_W, 2, 1, 2, 2'b11, 32'h1111_1111, 32'h2222_2222);
        run_op(ALU_ADD, -1, 0, -1, 0, 0, 0);
        run_op(ALU_ROR, 0, 1, 0, 2'b11, 32'h3333_3333, 32'h4444_4444);
        run_op(ALU_FSL, 1, 0, -1, 0, 0, 0);
        run_op(ALU_BEXT, 2, 0, -1, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        run_op(ALU_FSR, -1, 0, -1, 0, 0, 0);
        run_op(ALU_BEXT, -1, 0, -1, 0, 0, 0);
        run_op(ALU_SUB, -1, 0, -1, 0, 0, 0);
        run_op(ALU_CMIX, -1, 0, -1, 0, 0, 0);
        idle(2);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        op = ALU_BEXT; req = 1; kill = 0; we = 2'b01; d[0] = 32'h1234; d[1] = 0;
        @(negedge clk);
        we = 2'b00;
        #1;
        n_vec++; if (busy !== 1'b1 || q[0] !== 32'h1234) begin
            n_err++; $display("FAIL pre_reset got busy=%b imd0=%h exp busy=1 imd0=00001234", busy, q[0]);
        end
        #1;
        rst_ni = 0; req = 0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_ni = 1;
        m_q[0] = 0; m_q[1] = 0; exp_scnt = 0;
    endtask

`ifdef IBEX_ALU_MC_PERF_EN
    task automatic test_perf;
        run_op(ALU_FSR, -1, 0, -1, 0, 0, 0);
        run_op(ALU_BEXT, -1, 0, -1, 0, 0, 0);
        @(negedge clk);
        req = 0;
        #1;
        n_vec++; if (scnt !== 32'd4) begin n_err++; $display("FAIL perf_cnt got=%0d exp=4", scnt); end
    endtask
`endif

    task automatic test_random;
        for (int n = 0; n < 80; n++) begin
            alu_op_e o;
            int      ab;
            case ($urandom_range(2))
                0: o = single_ops[$urandom_range(9)];
                1: o = two_ops[$urandom_range(5)];
                default: o = iter_ops[$urandom_range(7)];
            endcase
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(lat_of(o) - 1)) : -1;
            run_op(o, ab, 1'($urandom_range(1)), -1, 0, 0, 0);
            if ($urandom_range(2) == 0) idle(1);
        end
        @(negedge clk);
        req = 0;
        #1;
`ifdef IBEX_ALU_MC_PERF_EN
        n_vec++; if (scnt !== 32'(exp_scnt)) begin n_err++; $display("FAIL random_cnt got=%0d exp=%0d", scnt, exp_scnt); end
`endif
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL random_end busy got=%b exp=0", busy); end
    endtask

    initial begin
        d[0] = 0; d[1] = 0;
        m_q[0] = 0; m_q[1] = 0;
        test_reset;
        test_single;
        test_two;
        test_iter;
        test_kill;
        test_back_to_back;
        test_async_reset;
`ifdef IBEX_ALU_MC_PERF_EN
        test_perf;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ibex_alu_mc_ctrl.md
Name: ibex_alu_mc_ctrl

Overview:
Sequencer for multi-cycle ALU operations. Sits between the ID/EX controller and the ALU datapath:
- drives the ALU's first-cycle flag;
- owns the two 32-bit intermediate-value registers the ALU reads and writes;
- generates stall/done handshake back to the ID stage.
Single-cycle ops pass through with zero added latency; RV32B rotate/funnel/ternary ops take 2 cycles; bit extract/deposit and CRC ops iterate for a parameterised count.

Parameters:
RV32B, ibex_pkg::RV32BNone, bitmanip config; RV32BNone forces every op single-cycle and removes all state except the imd registers.
ITER_CYCLES, 4, total cycles for iterative ops (BEXT, BDEP, CRC32*); legal range 3..32.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  valid ALU instruction in EX; held high until done_o
operator_i  in  ibex_pkg::alu_op_e  ALU operation; stable while req_i high
kill_i  in  1  flush/abort current instruction
imd_val_d_i  in  2x32  next intermediate values from ALU
imd_val_we_i  in  2  per-register write enables from ALU
imd_val_q_o  out  2x32  intermediate values to ALU
instr_first_cycle_o  out  1  ALU first-cycle flag
stall_o  out  1  EX not finished; ID must hold
done_o  out  1  result valid this cycle
busy_o  out  1  FSM not in IDLE

Behaviour:
Reset values:
- FSM = IDLE, counter = 0, imd_val_q_o = 0.
- instr_first_cycle_o = 1, stall_o = 0, done_o = 0, busy_o = 0.

Op classes (decoded from operator_i; all ops are SINGLE when RV32B == RV32BNone):
- TWO: ROL, ROR, FSL, FSR, CMIX, CMOV.
- ITER: BEXT, BDEP, CRC32_B/H/W, CRC32C_B/H/W.
- SINGLE: everything else.

FSM states: IDLE, LAST, ITER.
- IDLE: instr_first_cycle_o = 1.
  - req_i & SINGLE: done_o = 1, stall_o = 0, stay IDLE (0 extra cycles).
  - req_i & TWO: stall_o = 1, go to LAST.
  - req_i & ITER: stall_o = 1, counter <= ITER_CYCLES-2, go to ITER.
- ITER: instr_first_cycle_o = 0, stall_o = 1. Counter decrements each cycle; at 0 go to LAST.
- LAST: instr_first_cycle_o = 0, done_o = 1, stall_o = 0, go to IDLE.
- Latency: SINGLE 1 cycle, TWO 2 cycles, ITER exactly ITER_CYCLES cycles (req cycle through done cycle inclusive).
- Back-to-back: a new req_i in the cycle after LAST starts a fresh op from IDLE. No bubble is required, because LAST always returns to IDLE.

Abort and reset:
- kill_i or ~req_i while busy: next state IDLE, counter cleared; done_o and stall_o forced 0 that cycle.
- kill_i in IDLE: done_o = 0.
- Async reset mid-op returns to IDLE immediately.

imd registers:
- imd_val_q[i] <= imd_val_d_i[i] when imd_val_we_i[i] & req_i & ~kill_i.
- Not cleared on completion or kill; only reset clears them.
- Both bits set: both registers written in the same cycle.

Outputs: done_o and stall_o are mutually exclusive; stall_o implies req_i.

Assertions:
- operator_i stable while busy_o & req_i.
- ITER_CYCLES range check.
- One-hot state.
- No done_o without req_i.

Optional Feature:
IBEX_ALU_MC_PERF_EN
- Defined: adds output mc_stall_cnt_o (32 bits).
  - Counts cycles with stall_o = 1.
  - Saturates at all-ones; reset to 0.
  - Adds output mc_op_done_o (1 bit), a pulse when a TWO or ITER op completes.
- Undefined: ports absent, no counter flops. Core behaviour is identical in both cases.

Decomposition:
- ibex_pkg: add alu_mc_state_e (IDLE, LAST, ITER).
- ibex_pkg: add function alu_mc_class(alu_op_e, rv32b_e) returning enum {ALU_MC_SINGLE, ALU_MC_TWO, ALU_MC_ITER}.
- ibex_pkg: add constant ALU_MC_ITER_MAX = 32.
- The imd register pair is the natural sub-module: ibex_alu_imd_regs (2x32 flops with per-register write enables and async reset). The FSM and counter stay in the top.

Test Plan:
- ADD with req_i = 1 from reset -> done_o = 1 same cycle, stall_o = 0, first_cycle = 1, busy_o = 0.
- ROL, req held 2 cycles -> cycle0 stall = 1 / first = 1; cycle1 done = 1 / first = 0; then IDLE. Same op with RV32B = RV32BNone -> done in cycle0.
- BDEP with ITER_CYCLES = 4 -> stall for cycles 0-2, done at cycle 3; first_cycle = 1 only in cycle 0. imd_val_we_i = 2'b01 with d = 32'hDEADBEEF at cycle1 -> imd_val_q_o[0] = 32'hDEADBEEF from cycle2.
- CRC32_W with kill_i in cycle 2 -> no done_o, IDLE next cycle. Next ADD completes in one cycle; a write requested in the kill cycle is ignored.
- rst_ni low during ITER with imd_val_q_o = 32'h1234 -> immediately IDLE, outputs at reset values, imd_val_q_o = 0.
- IBEX_ALU_MC_PERF_EN: FSR followed by BEXT (ITER_CYCLES = 4) -> mc_stall_cnt_o = 4, two mc_op_done_o pulses.
